mbldcm_hall_decoder: RTL and testbench
======================================

Name: mbldcm_hall_decoder

Overview:
Receive-side companion to the BLDC drive block. Samples the motor's three Hall sensors and converts them into a commutation phase 0..5. Measures rotation direction and the time between transitions, and detects stall, illegal codes and skipped steps. Exposes the results through an Avalon-MM slave (2-bit word address) and a level interrupt, so software can close the speed loop on the drive block's frequency target.

Parameters:
pFilterCycles, 16'd4, consecutive identical synchronized samples required before a new Hall code is accepted (minimum 1).
pTimeoutCycles, 32'd50000000, idle clocks since the last accepted transition before the stop condition is declared.
pInvertHall, 3'b000, per-input inversion applied after synchronization; bit2=U, bit1=V, bit0=W.

Ports:
iClock  in  1  system clock.
iReset_n  in  1  asynchronous active-low reset; all flops are cleared on assertion.
iAddr  in  2  Avalon-MM word address.
iRead  in  1  read strobe.
oRdata  out  32  read data.
iWrite  in  1  write strobe.
iWdata  in  32  write data.
oResp  out  2  response code; always 2'b00 (OKAY).
iHu, iHv, iHw  in  1 each  raw asynchronous Hall sensor inputs.
oPhase  out  3  current phase 0..5.
oPhaseValid  out  1  high when the accepted code is legal.
oDir  out  1  rotation direction: 0 = forward (phase +1), 1 = reverse (phase -1).
oStop  out  1  stall/timeout indication.
oIrq  out  1  interrupt, level, equal to CTRL.en & CTRL.pend.

Behaviour:
- Input path: 2-flop synchronizer per Hall input, then XOR with pInvertHall. Form code = {U,V,W}.
- Filter:
  - A candidate code plus a 16-bit stability counter.
  - The counter restarts when the sample differs from the candidate.
  - When the counter reaches pFilterCycles, the candidate is copied to the accepted code.
  - Latency from a clean input change to the accepted code = 2 + pFilterCycles clocks.
- Code map: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5.
  - 000 and 111 are illegal: oPhaseValid=0, oPhase holds its last legal value, sticky ERR_INV is set.
- Transition event: the accepted code changes to a legal code different from the previous legal code.
- Period counter:
  - 32-bit, increments every clock, saturates at 0xFFFFFFFF.
  - Cleared to 0 on each transition event.
  - On the event, the pre-clear count is latched into PERIOD. Exception: the stop flag was set before the event, in which case PERIOD stays 0.
- Direction:
  - new = (old+1) mod 6 -> oDir=0.
  - new = (old+5) mod 6 -> oDir=1.
  - Any other jump: oDir unchanged, sticky ERR_SKIP set; PERIOD is still latched.
- Stop:
  - oStop=1 when the period counter reaches pTimeoutCycles; PERIOD is forced to 0 at the same time.
  - oStop clears on the next transition event.
- Interrupt: every transition event sets CTRL.pend.
- Register map (read latency 1: oRdata is registered and valid the cycle after iRead; holds its value otherwise; unused bits read 0):
  - addr0 STATUS, R/W1C: [2:0] phase, [3] valid, [4] dir, [5] stop, [8] ERR_INV, [9] ERR_SKIP. Writing 1 to bit 8 or 9 clears that flag; other bits are ignored.
  - addr1 PERIOD, RO: writes are ignored.
  - addr2 EDGES, R/W: 32-bit transition-event count, wraps 0xFFFFFFFF->0. Any write clears it to 0.
  - addr3 CTRL: [0] en (R/W), [1] pend (R/W1C).
- Simultaneous events:
  - A flag set and its W1C in the same cycle -> set wins.
  - EDGES clear and increment in the same cycle -> EDGES=1.
- Reset values:
  - oRdata=0, oResp=0, oPhase=0, oPhaseValid=0, oDir=0, oStop=0, oIrq=0.
  - Accepted and candidate code = 000, so the block comes out of reset illegal until sensors settle.
  - Counters, PERIOD, EDGES and all flags = 0.
- The first legal code after reset or after an illegal code is not a transition event: no PERIOD latch, no EDGES increment, no interrupt. It only updates oPhase and valid.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous), including a pending read.

Test Plan:
1. Reset release, Hall=001 held -> after 2+4 clocks oPhase=0 and oPhaseValid=1; EDGES=0, oIrq=0.
2. Forward sequence 001,011,010,110 with 1000 clocks between steps, en=1 -> oDir=0, PERIOD=1000 (±filter latency, constant), EDGES=3, oIrq=1. W1C CTRL bit1 -> oIrq=0.
3. Reverse step 011->001 -> oDir=1. Then jump 001->110 -> ERR_SKIP=1 and oDir unchanged. Write STATUS 0x200 -> ERR_SKIP=0.
4. Glitch: change Hall for 3 clocks (pFilterCycles=4), then return -> no phase change, EDGES unchanged. Hold 111 for 10 clocks -> oPhaseValid=0, ERR_INV=1, oPhase unchanged.
5. No transition for pTimeoutCycles (bench override: 100) -> oStop=1 and PERIOD=0. Next legal step -> oStop=0, PERIOD still 0. Following step -> PERIOD nonzero.
6. Write EDGES in the same cycle as a transition event -> EDGES=1. Assert iReset_n low mid-read -> oRdata=0 and all outputs at their reset values within the same cycle.

Source files
------------

// File: rtl/mbldcm_hall_decoder.sv
// Hall sensor front end for the BLDC drive: synchronises and debounces the three
// Hall inputs, decodes the commutation phase, times the steps and exposes it all over Avalon-MM.
module mbldcm_hall_decoder #(
  parameter logic [15:0] pFilterCycles  = 16'd4,
  parameter logic [31:0] pTimeoutCycles = 32'd50000000,
  parameter logic [2:0]  pInvertHall    = 3'b000
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [1:0]  iAddr,
  input  logic        iRead,
  output logic [31:0] oRdata,
  input  logic        iWrite,
  input  logic [31:0] iWdata,
  output logic [1:0]  oResp,
  input  logic        iHu,
  input  logic        iHv,
  input  logic        iHw,
  output logic [2:0]  oPhase,
  output logic        oPhaseValid,
  output logic        oDir,
  output logic        oStop,
  output logic        oIrq
);

  localparam logic [15:0] cFilter = (pFilterCycles == 16'd0) ? 16'd1 : pFilterCycles;

  logic [2:0]  sync1, sync2, sample, cand, accCode;
  logic [15:0] stableCnt, nextCnt;
  logic        acceptNow;
  logic [2:0]  newPhase, phasePlus, phaseMinus;
  logic        newLegal, stepEvent, stepFwd, stepRev;
  logic [31:0] periodCnt, periodReg, edgeCnt, statusWord;
  logic        errInv, errSkip, ctrlEn, ctrlPend;
  logic        wrStatus, wrEdges, wrCtrl;
  logic        unusedWdata;

  assign sample = sync2 ^ pInvertHall;
  assign oResp  = '0;
  assign oIrq   = ctrlEn & ctrlPend;
  assign unusedWdata = ^{iWdata[31:10], iWdata[7:2]};

  assign wrStatus = iWrite && (iAddr == 2'd0);
  assign wrEdges  = iWrite && (iAddr == 2'd2);
  assign wrCtrl   = iWrite && (iAddr == 2'd3);

  // nextCnt counts consecutive samples equal to the candidate, including this one,
  // so acceptance lands exactly pFilterCycles clocks after the synchroniser output changes.
  always_comb begin
    nextCnt = 16'd1;
    if (sample == cand)
      nextCnt = (stableCnt >= cFilter) ? stableCnt : stableCnt + 16'd1;
    acceptNow = (nextCnt >= cFilter) && (sample != accCode);
  end

  always_comb begin
    newLegal = 1'b1;
    newPhase = oPhase;
    case (sample)
      3'b001:  newPhase = 3'd0;
      3'b011:  newPhase = 3'd1;
      3'b010:  newPhase = 3'd2;
      3'b110:  newPhase = 3'd3;
      3'b100:  newPhase = 3'd4;
      3'b101:  newPhase = 3'd5;
      default: newLegal = 1'b0;
    endcase
  end

  always_comb begin
    phasePlus  = (oPhase == 3'd5) ? 3'd0 : oPhase + 3'd1;
    phaseMinus = (oPhase == 3'd0) ? 3'd5 : oPhase - 3'd1;
    stepEvent  = acceptNow && newLegal && oPhaseValid && (newPhase != oPhase);
    stepFwd    = (newPhase == phasePlus);
    stepRev    = (newPhase == phaseMinus);
  end

  always_comb begin
    statusWord       = '0;
    statusWord[2:0]  = oPhase;
    statusWord[3]    = oPhaseValid;
    statusWord[4]    = oDir;
    statusWord[5]    = oStop;
    statusWord[8]    = errInv;
    statusWord[9]    = errSkip;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      cand        <= '0;
      accCode     <= '0;
      stableCnt   <= '0;
      oPhase      <= '0;
      oPhaseValid <= 1'b0;
      oDir        <= 1'b0;
      oStop       <= 1'b0;
      errInv      <= 1'b0;
      errSkip     <= 1'b0;
      periodCnt   <= '0;
      periodReg   <= '0;
      edgeCnt     <= '0;
      ctrlEn      <= 1'b0;
      ctrlPend    <= 1'b0;
      oRdata      <= '0;
    end else begin
      sync1     <= {iHu, iHv, iHw};
      sync2     <= sync1;
      cand      <= sample;
      stableCnt <= nextCnt;

      if (acceptNow) begin
        accCode <= sample;
        if (newLegal) begin
          oPhase      <= newPhase;
          oPhaseValid <= 1'b1;
        end else begin
          oPhaseValid <= 1'b0;
        end
      end

      if (acceptNow && !newLegal)            errInv <= 1'b1;
      else if (wrStatus && iWdata[8])        errInv <= 1'b0;

      if (stepEvent && !stepFwd && !stepRev) errSkip <= 1'b1;
      else if (wrStatus && iWdata[9])        errSkip <= 1'b0;

      if (stepEvent && stepFwd)      oDir <= 1'b0;
      else if (stepEvent && stepRev) oDir <= 1'b1;

      // A step that ends a stall reports PERIOD 0: the elapsed time is not a speed.
      if (stepEvent) begin
        periodCnt <= '0;
        periodReg <= oStop ? '0 : periodCnt;
        oStop     <= 1'b0;
      end else begin
        if (periodCnt != '1) periodCnt <= periodCnt + 32'd1;
        if (periodCnt == pTimeoutCycles) begin
          oStop     <= 1'b1;
          periodReg <= '0;
        end
      end

      if (wrEdges)        edgeCnt <= stepEvent ? 32'd1 : 32'd0;
      else if (stepEvent) edgeCnt <= edgeCnt + 32'd1;

      if (wrCtrl) ctrlEn <= iWdata[0];
      if (stepEvent)                  ctrlPend <= 1'b1;
      else if (wrCtrl && iWdata[1])   ctrlPend <= 1'b0;

      if (iRead) begin
        case (iAddr)
          2'd0:    oRdata <= statusWord;
          2'd1:    oRdata <= periodReg;
          2'd2:    oRdata <= edgeCnt;
          default: oRdata <= {30'd0, ctrlPend, ctrlEn};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mbldcm_hall_decoder.sv
// Scoreboard bench for mbldcm_hall_decoder: reads queue their expected values,
// a monitor pops and compares each response the cycle after the read strobe.
module tb_mbldcm_hall_decoder;

  logic        iClock = 1'b0;
  logic        iReset_n;
  logic [1:0]  iAddr;
  logic        iRead;
  logic [31:0] oRdata;
  logic        iWrite;
  logic [31:0] iWdata;
  logic [1:0]  oResp;
  logic        iHu, iHv, iHw;
  logic [2:0]  oPhase;
  logic        oPhaseValid, oDir, oStop, oIrq;
  logic [6:0]  pins;

  assign pins = {oIrq, oStop, oDir, oPhaseValid, oPhase};

  mbldcm_hall_decoder #(
    .pFilterCycles (16'd4),
    .pTimeoutCycles(32'd100),
    .pInvertHall   (3'b000)
  ) dut (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iAddr      (iAddr),
    .iRead      (iRead),
    .oRdata     (oRdata),
    .iWrite     (iWrite),
    .iWdata     (iWdata),
    .oResp      (oResp),
    .iHu        (iHu),
    .iHv        (iHv),
    .iHw        (iHw),
    .oPhase     (oPhase),
    .oPhaseValid(oPhaseValid),
    .oDir       (oDir),
    .oStop      (oStop),
    .oIrq       (oIrq)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          pinChk;
    logic [6:0]  pins;
  } expT;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic setHall(input logic [2:0] c);
    {iHu, iHv, iHw} = c;
  endtask

  task automatic rdChk(input logic [1:0] a, input string nm, input logic [31:0] lo,
                       input logic [31:0] hi, input bit pc, input logic [6:0] p);
    expT e;
    e.name = nm; e.lo = lo; e.hi = hi; e.pinChk = pc; e.pins = p;
    expQ.push_back(e);
    iAddr = a;
    iRead = 1'b1;
    @(negedge iClock);
    iRead = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] v);
    rdChk(a, nm, v, v, 1'b0, 7'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    iAddr  = a;
    iWdata = d;
    iWrite = 1'b1;
    @(negedge iClock);
    iWrite = 1'b0;
  endtask

  // Monitor: a read strobed at this edge presents its data just after the edge.
  initial begin
    expT e;
    forever begin
      @(posedge iClock);
      if (iRead && iReset_n) begin
        #1;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected read: got %h, want no response", oRdata);
        end else begin
          e = expQ.pop_front();
          compared++;
          if (oRdata < e.lo || oRdata > e.hi || oResp !== 2'b00) begin
            mismatched++;
            $display("FAIL %s: got %h resp %0d, want %h..%h resp 0", e.name, oRdata, oResp, e.lo, e.hi);
          end
          if (e.pinChk) begin
            compared++;
            if (pins !== e.pins) begin
              mismatched++;
              $display("FAIL %s pins {irq,stop,dir,valid,phase}: got %b, want %b", e.name, pins, e.pins);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d reads outstanding", expQ.size());
    $fatal(1, "watchdog");
  end

  initial begin
    iAddr = '0; iRead = 1'b0; iWrite = 1'b0; iWdata = '0;
    setHall(3'b001);
    iReset_n = 1'b0;
    waitClk(3);
    chk("reset rdata", oRdata, 32'd0);
    chk("reset pins", {25'd0, pins}, 32'd0);
    iReset_n = 1'b1;

    // Settling: accepted exactly 2+4 clocks after release
    waitClk(4);
    rdChk(2'd0, "status before accept", 32'h0, 32'h0, 1'b1, 7'b0000000);
    waitClk(1);
    rdChk(2'd0, "status accepted", 32'h8, 32'h8, 1'b1, 7'b0001000);
    rd(2'd2, "edges after reset", 32'd0);
    rd(2'd3, "ctrl after reset", 32'd0);
    wr(2'd3, 32'h1);

    // Forward steps 80 clocks apart
    setHall(3'b011); waitClk(80);
    setHall(3'b010); waitClk(80);
    setHall(3'b110); waitClk(10);
    rdChk(2'd0, "status forward", 32'hB, 32'hB, 1'b1, 7'b1001011);
    rdChk(2'd1, "period forward", 32'd74, 32'd86, 1'b0, 7'd0);
    rd(2'd2, "edges forward", 32'd3);
    rd(2'd3, "ctrl pending", 32'h3);
    wr(2'd3, 32'h3);
    rdChk(2'd3, "ctrl pend cleared", 32'h1, 32'h1, 1'b1, 7'b0001011);

    // Reverse steps, then a skipped step
    setHall(3'b010); waitClk(80);
    setHall(3'b011); waitClk(80);
    setHall(3'b001); waitClk(80);
    rdChk(2'd0, "status reverse", 32'h18, 32'h18, 1'b1, 7'b1011000);
    setHall(3'b110); waitClk(10);
    rdChk(2'd0, "status skip", 32'h21B, 32'h21B, 1'b1, 7'b1011011);
    rd(2'd2, "edges after skip", 32'd7);
    wr(2'd0, 32'h200);
    rd(2'd0, "skip cleared", 32'h1B);

    // Glitch shorter than the filter, then an illegal code
    setHall(3'b100); waitClk(3);
    setHall(3'b110); waitClk(10);
    rd(2'd0, "status after glitch", 32'h1B);
    rd(2'd2, "edges after glitch", 32'd7);
    setHall(3'b111); waitClk(10);
    rdChk(2'd0, "status illegal", 32'h113, 32'h113, 1'b1, 7'b1010011);
    setHall(3'b110); waitClk(10);
    rd(2'd0, "status relegal", 32'h11B);
    rd(2'd2, "edges relegal", 32'd7);
    wr(2'd0, 32'h100);
    rd(2'd0, "inv cleared", 32'h1B);

    // Stall past the 100-clock timeout
    waitClk(150);
    rdChk(2'd0, "status stalled", 32'h3B, 32'h3B, 1'b1, 7'b1111011);
    rd(2'd1, "period stalled", 32'd0);
    setHall(3'b100); waitClk(10);
    rd(2'd0, "status after stall", 32'h0C);
    rd(2'd1, "period after stall", 32'd0);
    waitClk(48);
    setHall(3'b101); waitClk(10);
    rdChk(2'd1, "period resumed", 32'd54, 32'd66, 1'b0, 7'd0);
    rd(2'd0, "status phase5", 32'h0D);
    rd(2'd2, "edges before clear", 32'd9);

    // EDGES write lands on the same edge as a step event
    setHall(3'b001); waitClk(5);
    wr(2'd2, 32'hDEAD);
    waitClk(2);
    rdChk(2'd2, "edges clear+inc", 32'd1, 32'd1, 1'b1, 7'b1001000);

    // Reset in the middle of a read
    iAddr = 2'd2;
    iRead = 1'b1;
    #2 iReset_n = 1'b0;
    #1;
    chk("midread reset rdata", oRdata, 32'd0);
    chk("midread reset pins", {25'd0, pins}, 32'd0);
    chk("midread reset resp", {30'd0, oResp}, 32'd0);
    @(negedge iClock);
    iRead = 1'b0;
    waitClk(1);
    iReset_n = 1'b1;
    waitClk(8);
    rd(2'd2, "edges after re-reset", 32'd0);
    rdChk(2'd0, "status after re-reset", 32'h8, 32'h8, 1'b1, 7'b0001000);

    waitClk(3);
    chk("scoreboard drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
